// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_pkg
// Description : Shared types and codes for the multicycle MIPS controller:
//               state enum, opcode/funct values, ALU and mux-select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;

    // R-type funct codes (Instr[5:0])
    localparam logic [5:0] c_FUNCT_ADD = 6'b100000;
    localparam logic [5:0] c_FUNCT_SUB = 6'b100010;
    localparam logic [5:0] c_FUNCT_AND = 6'b100100;
    localparam logic [5:0] c_FUNCT_OR  = 6'b100101;
    localparam logic [5:0] c_FUNCT_SLT = 6'b101010;

    // ALU operation codes
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    // Register destination select
    localparam logic [1:0] c_REGDST_RT = 2'b00;
    localparam logic [1:0] c_REGDST_RD = 2'b01;
    localparam logic [1:0] c_REGDST_RA = 2'b10;

    // Write-back source select
    localparam logic [1:0] c_WB_ALU = 2'b00;
    localparam logic [1:0] c_WB_MEM = 2'b01;
    localparam logic [1:0] c_WB_PC  = 2'b10;

    // ALU B operand select
    localparam logic [1:0] c_SRCB_REG   = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // States that stall on the shared memory and are guarded by the wait counter
    function automatic logic is_wait_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : mips_alu_decoder
// Description : Maps an R-type funct field to the ALU operation code and
//               flags whether the funct is one the datapath supports.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    // Funct lookup; unsupported codes fall back to add and report invalid
    always_comb begin
        alu_control = c_ALU_ADD;
        funct_valid = 1'b1;
        case (funct)
            c_FUNCT_ADD: alu_control = c_ALU_ADD;
            c_FUNCT_SUB: alu_control = c_ALU_SUB;
            c_FUNCT_AND: alu_control = c_ALU_AND;
            c_FUNCT_OR:  alu_control = c_ALU_OR;
            c_FUNCT_SLT: alu_control = c_ALU_SLT;
            default:     funct_valid = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_control
// Description : Multicycle MIPS control FSM with memory-wait timeout.
//               Optional feature macro: MIPS_MC_JAL_EN (adds the jal state).
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_control
    import mips_mc_pkg::*;
#(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       mem_timeout
);

    // The counter only has to reach WAIT_MAX-1: the final wait cycle is
    // recognised combinationally from that value.
    localparam int               c_CNT_W    = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WAIT_MAX - 1);

    state_t              r_state;
    state_t              w_next_state;
    state_t              w_decode_next;
    logic [c_CNT_W-1:0]  r_wait_cnt;
    logic                w_wait_state;
    logic                w_timeout;
    logic                w_op_legal;
    logic [2:0]          w_alu_funct;
    logic                w_funct_valid;

    mips_alu_decoder u_alu_decoder (
        .funct       (funct),
        .alu_control (w_alu_funct),
        .funct_valid (w_funct_valid)
    );

    assign w_wait_state = is_wait_state(r_state);
    assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == c_CNT_LAST) && !reset;
    assign state        = r_state;
    assign mem_timeout  = w_timeout;
    assign illegal_op   = (r_state == S_DECODE) && !w_op_legal;

    // State register and wait counter; counter restarts on every state entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_FETCH;
            r_wait_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if ((w_next_state != r_state) || w_timeout) begin
                r_wait_cnt <= '0;
            end else if (w_wait_state && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
            end
        end
    end

    // Opcode dispatch out of DECODE and legality of the fetched instruction
    always_comb begin
        w_decode_next = S_FETCH;
        w_op_legal    = 1'b1;
        case (op)
            c_OP_LW, c_OP_SW: w_decode_next = S_MEMADR;
            c_OP_RTYPE: begin
                if (w_funct_valid) w_decode_next = S_EXEC;
                else               w_op_legal    = 1'b0;
            end
            c_OP_BEQ:  w_decode_next = S_BRANCH;
            c_OP_ADDI: w_decode_next = S_ADDIEX;
            c_OP_J:    w_decode_next = S_JUMP;
`ifdef MIPS_MC_JAL_EN
            c_OP_JAL:  w_decode_next = S_JAL;
`endif
            default:   w_op_legal = 1'b0;
        endcase
    end

    // Per-state control outputs and next state; everything idles at 0
    always_comb begin
        w_next_state = r_state;
        pc_en        = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        reg_dst      = c_REGDST_RT;
        mem_to_reg   = c_WB_ALU;
        alu_src_b    = c_SRCB_REG;
        pc_src       = c_PCSRC_ALU;
        alu_control  = c_ALU_AND;
        case (r_state)
            S_FETCH: begin
                mem_read    = 1'b1;
                alu_src_b   = c_SRCB_FOUR;
                alu_control = c_ALU_ADD;
                // Writes are suppressed while reset is held
                ir_write    = mem_ready && !reset;
                pc_en       = mem_ready && !reset;
                if (mem_ready) w_next_state = S_DECODE;
                else if (w_timeout) w_next_state = S_FETCH;
            end
            S_DECODE: begin
                alu_src_b    = c_SRCB_IMMSH;
                alu_control  = c_ALU_ADD;
                w_next_state = w_decode_next;
            end
            S_MEMADR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = c_SRCB_IMM;
                alu_control  = c_ALU_ADD;
                w_next_state = (op == c_OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (mem_ready)      w_next_state = S_MEMWB;
                else if (w_timeout) w_next_state = S_FETCH;
            end
            S_MEMWB: begin
                reg_write    = 1'b1;
                reg_dst      = c_REGDST_RT;
                mem_to_reg   = c_WB_MEM;
                w_next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (mem_ready || w_timeout) w_next_state = S_FETCH;
            end
            S_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = c_SRCB_REG;
                alu_control  = w_alu_funct;
                w_next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write    = 1'b1;
                reg_dst      = c_REGDST_RD;
                mem_to_reg   = c_WB_ALU;
                w_next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_src_b    = c_SRCB_REG;
                alu_control  = c_ALU_SUB;
                pc_src       = c_PCSRC_ALUOUT;
                pc_en        = zero;
                w_next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a    = 1'b1;
                alu_src_b    = c_SRCB_IMM;
                alu_control  = c_ALU_ADD;
                w_next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write    = 1'b1;
                reg_dst      = c_REGDST_RT;
                mem_to_reg   = c_WB_ALU;
                w_next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src       = c_PCSRC_JUMP;
                pc_en        = 1'b1;
                w_next_state = S_FETCH;
            end
`ifdef MIPS_MC_JAL_EN
            S_JAL: begin
                reg_write    = 1'b1;
                reg_dst      = c_REGDST_RA;
                mem_to_reg   = c_WB_PC;
                pc_src       = c_PCSRC_JUMP;
                pc_en        = 1'b1;
                w_next_state = S_FETCH;
            end
`endif
            default: w_next_state = S_FETCH;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_mc_control
// Description : Randomized scoreboard bench for mips_mc_control. The driver
//               advances an instruction-level reference model and queues the
//               expected output vector; a monitor compares on each negedge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mc_control;

    localparam int WAIT_MAX = 15;
    localparam int N_CYCLES = 6000;

    localparam int FETCH = 0,  DECODE = 1, MEMADR = 2,  MEMRD = 3,  MEMWB = 4;
    localparam int MEMWR = 5,  EXEC = 6,   ALUWB = 7,   BRANCH = 8, ADDIEX = 9;
    localparam int ADDIWB = 10, JUMP = 11, JAL = 12;

    logic       clk = 1'b1;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal_op, mem_timeout;

    mips_mc_control #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_b   (alu_src_b),
        .pc_src      (pc_src),
        .alu_control (alu_control),
        .state       (state),
        .illegal_op  (illegal_op),
        .mem_timeout (mem_timeout)
    );

    always #5 clk = ~clk;

    logic [23:0] exp_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    // Reference model: current step, wait cycles spent, remaining route of
    // the instruction in flight, and the stall length chosen for this wait.
    int m_state;
    int m_wait;
    int m_budget;
    int route[$];

    function automatic void alu_of(input logic [5:0] f, output logic [2:0] a, output bit v);
        v = 1'b1;
        a = 3'b010;
        case (f)
            6'b100000: a = 3'b010;
            6'b100010: a = 3'b110;
            6'b100100: a = 3'b000;
            6'b100101: a = 3'b001;
            6'b101010: a = 3'b111;
            default:   v = 1'b0;
        endcase
    endfunction

    task automatic model_cycle(output logic [23:0] e);
        logic pe, io, mr, mw, iw, rw, sa, ill, tmo;
        logic [1:0] rd, m2r, sb, ps;
        logic [2:0] ac, fa;
        bit fv;
        int nxt;
        {pe, io, mr, mw, iw, rw, sa, ill, tmo} = '0;
        rd = 2'b00; m2r = 2'b00; sb = 2'b00; ps = 2'b00; ac = 3'b000;
        if (reset) begin
            m_state = FETCH;
            m_wait  = 0;
            route.delete();
        end
        alu_of(funct, fa, fv);
        case (m_state)
            FETCH:  begin mr = 1; sb = 2'b01; ac = 3'b010; iw = mem_ready && !reset; pe = iw; end
            DECODE: begin
                sb = 2'b11; ac = 3'b010;
                route.delete();
                case (op)
                    6'b100011: route = {MEMADR, MEMRD, MEMWB};
                    6'b101011: route = {MEMADR, MEMWR};
                    6'b000000: if (fv) route = {EXEC, ALUWB};
                    6'b000100: route = {BRANCH};
                    6'b001000: route = {ADDIEX, ADDIWB};
                    6'b000010: route = {JUMP};
`ifdef MIPS_MC_JAL_EN
                    6'b000011: route = {JAL};
`endif
                    default: ;
                endcase
                ill = (route.size() == 0);
            end
            MEMADR: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            MEMRD:  begin mr = 1; io = 1; end
            MEMWB:  begin rw = 1; m2r = 2'b01; end
            MEMWR:  begin mw = 1; io = 1; end
            EXEC:   begin sa = 1; ac = fa; end
            ALUWB:  begin rw = 1; rd = 2'b01; end
            BRANCH: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = zero; end
            ADDIEX: begin sa = 1; sb = 2'b10; ac = 3'b010; end
            ADDIWB: begin rw = 1; end
            JUMP:   begin ps = 2'b10; pe = 1; end
            JAL:    begin rw = 1; rd = 2'b10; m2r = 2'b10; ps = 2'b10; pe = 1; end
            default: ;
        endcase
        if (reset) begin
            nxt = FETCH;
        end else if ((m_state == FETCH || m_state == MEMRD || m_state == MEMWR) && !mem_ready) begin
            nxt = m_state;
            if (m_wait + 1 == WAIT_MAX) begin
                tmo    = 1;
                nxt    = FETCH;
                m_wait = 0;
                route.delete();
            end else begin
                m_wait++;
            end
        end else begin
            m_wait = 0;
            if (m_state == FETCH)      nxt = DECODE;
            else if (route.size() > 0) nxt = route.pop_front();
            else                       nxt = FETCH;
        end
        e = {pe, io, mr, mw, iw, rw, sa, rd, m2r, sb, ps, ac, 4'(m_state), ill, tmo};
        m_state = nxt;
    endtask

    // Monitor: compare DUT outputs with the queued expectation each negedge
    initial begin
        logic [23:0] act, e;
        forever begin
            @(negedge clk);
            act = {pc_en, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a,
                   reg_dst, mem_to_reg, alu_src_b, pc_src, alu_control, state,
                   illegal_op, mem_timeout};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL no_expected t=%0t: actual %b required <queued vector>", $time, act);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL outputs t=%0t: actual %b required %b (pe,io,mr,mw,iw,rw,sa,rd,m2r,sb,ps,ac,st,ill,tmo)",
                             $time, act, e);
                end
            end
            vectors++;
            if (mem_read && mem_write) begin
                miscompares++;
                $display("FAIL mem_rw_exclusive t=%0t: actual mr=%b mw=%b required not both 1",
                         $time, mem_read, mem_write);
            end
        end
    end

    // Driver: randomized instructions, stalls, zero flag and reset pulses
    initial begin
        logic [23:0] e;
        logic [5:0]  ops [9];
        logic [5:0]  functs [7];
        int          pick;
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100,
                   6'b001000, 6'b000010, 6'b000011, 6'b111111};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                   6'b000111, 6'b000000};
        reset = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        m_state = FETCH; m_wait = 0; m_budget = 0;
        model_cycle(e);
        exp_q.push_back(e);
        for (int cyc = 1; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            if (cyc < 3)                                              reset = 1'b1;
            else if (reset)                                           reset = 1'b0;
            else if (m_state == MEMRD && $urandom_range(0, 7) == 0)   reset = 1'b1;
            else if ($urandom_range(0, 299) == 0)                     reset = 1'b1;
            zero = 1'($urandom_range(0, 1));
            if (m_state == FETCH) begin
                op = ops[$urandom_range(0, 8)];
                if ($urandom_range(0, 9) == 0) op = 6'($urandom);
                funct = functs[$urandom_range(0, 6)];
                if ($urandom_range(0, 9) == 0) funct = 6'($urandom);
            end
            if (reset) begin
                mem_ready = 1'b0;
            end else if (m_state == FETCH || m_state == MEMRD || m_state == MEMWR) begin
                if (m_wait == 0) begin
                    pick = $urandom_range(0, 9);
                    case (pick)
                        5:       m_budget = 1;
                        6:       m_budget = 3;
                        7:       m_budget = WAIT_MAX - 1;
                        8:       m_budget = WAIT_MAX;
                        9:       m_budget = WAIT_MAX + 5;
                        default: m_budget = 0;
                    endcase
                end
                mem_ready = (m_wait >= m_budget);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            model_cycle(e);
            exp_q.push_back(e);
        end
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
